// File: rtl/sqr_lite_v2.sv
// sqr_lite_v2 : AXI4-Lite slave that squares an operand with a serial shift-add
// multiplier (one multiplier bit per clock, OP_WIDTH clocks per operation).
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESET   clock, synchronous active-high reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*   write address, data and response channels
//   S_AXI_AR* / S_AXI_R*              read address and data channels
//   IRQ                               level interrupt, DONE & IRQ_EN
//
// Register map (byte address, decoded from addr[4:2])
//   0x00 CTRL      bit0 START (write-1, reads 0), bit1 IRQ_EN
//   0x04 STATUS    bit0 BUSY (RO), bit1 DONE (W1C)
//   0x08 OPERAND   [OP_WIDTH-1:0]
//   0x0C RESULT_LO result[31:0]
//   0x10 RESULT_HI result[2*OP_WIDTH-1:32]
//   0x14 COUNT     completed operations
//
// Engine states
//   state | meaning
//   IDLE  | waiting for START; result registers hold the last product
//   RUN   | one shift-add step per clock, OP_WIDTH steps in total
module sqr_lite_v2 #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int OP_WIDTH           = 16
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic                          IRQ
);

  localparam int CW = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;
  localparam int PW = 2 * OP_WIDTH;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  state_t state_q, state_d;

  logic                awready_q, arready_q, bvalid_q, rvalid_q;
  logic [31:0]         rdata_q;
  logic                irq_en_q, done_q;
  logic [OP_WIDTH-1:0] operand_q, mplier_q;
  logic [PW-1:0]       mcand_q, acc_q, result_q, acc_next;
  logic [CW-1:0]       bit_cnt_q;
  logic [31:0]         count_q;

  logic                wr_en, rd_en, start, last_bit, done_clr;
  logic [2:0]          wr_idx, rd_idx;
  logic [31:0]         op_cur, op_wr, rd_mux;
  logic [63:0]         result_ext;
  logic                unused_ok;

  // Ready is only raised while both valids are present, and AXI forbids a
  // master from dropping valid before ready, so the ready pulse is the handshake.
  assign wr_en  = awready_q;
  assign rd_en  = arready_q;
  assign wr_idx = S_AXI_AWADDR[4:2];
  assign rd_idx = S_AXI_ARADDR[4:2];

  assign start    = wr_en && (wr_idx == 3'd0) && S_AXI_WSTRB[0] && S_AXI_WDATA[0]
                    && (state_q == IDLE);
  assign last_bit = (state_q == RUN) && (bit_cnt_q == CW'(OP_WIDTH - 1));
  assign done_clr = wr_en && (wr_idx == 3'd1) && S_AXI_WSTRB[0] && S_AXI_WDATA[1];
  assign acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;

  assign op_cur = 32'(operand_q);
  always_comb begin
    op_wr = op_cur;
    for (int b = 0; b < 4; b++) begin
      if (S_AXI_WSTRB[b]) op_wr[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
    end
  end

  assign result_ext = 64'(result_q);

  always_comb begin
    rd_mux = 32'd0;
    case (rd_idx)
      3'd0: rd_mux = {30'd0, irq_en_q, 1'b0};
      3'd1: rd_mux = {30'd0, done_q, (state_q == RUN)};
      3'd2: rd_mux = op_cur;
      3'd3: rd_mux = result_ext[31:0];
      3'd4: rd_mux = result_ext[63:32];
      3'd5: rd_mux = count_q;
      default: rd_mux = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start)    state_d = RUN;
      RUN:  if (last_bit) state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      operand_q <= '0;
      mplier_q  <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      bit_cnt_q <= '0;
      count_q   <= 32'd0;
    end else begin
      // write channel
      awready_q <= 1'b0;
      if (!awready_q && !bvalid_q && S_AXI_AWVALID && S_AXI_WVALID) awready_q <= 1'b1;
      if (wr_en)             bvalid_q <= 1'b1;
      else if (S_AXI_BREADY) bvalid_q <= 1'b0;

      // read channel
      arready_q <= 1'b0;
      if (!arready_q && !rvalid_q && S_AXI_ARVALID) arready_q <= 1'b1;
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end

      // register file
      if (wr_en && (wr_idx == 3'd0) && S_AXI_WSTRB[0]) irq_en_q <= S_AXI_WDATA[1];
      if (wr_en && (wr_idx == 3'd2)) operand_q <= op_wr[OP_WIDTH-1:0];

      // completion set wins over a coincident W1C
      if (last_bit)      done_q <= 1'b1;
      else if (done_clr) done_q <= 1'b0;

      // engine datapath; the operand is copied so later OPERAND writes do not disturb it
      if (start) begin
        mcand_q   <= PW'(operand_q);
        mplier_q  <= operand_q;
        acc_q     <= '0;
        bit_cnt_q <= '0;
      end else if (state_q == RUN) begin
        acc_q     <= acc_next;
        mcand_q   <= mcand_q << 1;
        mplier_q  <= mplier_q >> 1;
        bit_cnt_q <= bit_cnt_q + CW'(1);
      end

      if (last_bit) begin
        result_q <= acc_next;
        count_q  <= count_q + 32'd1;
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign IRQ           = done_q & irq_en_q;

  // address bits below the word index and operand bits beyond OP_WIDTH are don't-care
  assign unused_ok = &{1'b0, S_AXI_AWADDR, S_AXI_ARADDR, op_wr, (C_S_AXI_DATA_WIDTH == 32)};

endmodule
